// File: rtl/squarer_seq_pkg.sv
// Shared types and constants for the sequential squarer.
// FSM state encoding and the default operand width live here.
package squarer_seq_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/squarer_seq_if.sv
// Request/result bundle of the sequential squarer.
// slave is the unit side, master is the requester side.
interface squarer_seq_if #(
    parameter int WIDTH = 8
);

    logic               start_i;
    logic [WIDTH-1:0]   root_i;
    logic               busy_o;
    logic               ready_o;
    logic [2*WIDTH-1:0] valor_o;

    modport slave (
        input  start_i,
        input  root_i,
        output busy_o,
        output ready_o,
        output valor_o
    );

    modport master (
        output start_i,
        output root_i,
        input  busy_o,
        input  ready_o,
        input  valor_o
    );

endinterface

// File: rtl/squarer_seq_ctrl.sv
// Control FSM of the squarer: sequences IDLE/CALC/DONE
// and counts the WIDTH shift-add steps.
module squarer_ctrl
    import squarer_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic load_o,
    output logic shift_en_o,
    output logic last_o,
    output logic busy_o,
    output logic done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_done;

    assign cnt_done = (cnt_q == CNT_LAST);

    // State and step counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_o     = 1'b0;
        shift_en_o = 1'b0;
        last_o     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                shift_en_o = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_done) begin
                    last_o  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == ST_CALC);
    assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/squarer_seq.sv
// Sequential squarer: root*root by shift-add over WIDTH cycles.
// Holds the datapath; sequencing comes from squarer_ctrl.
module squarer_seq
    import squarer_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    squarer_seq_if.slave bus
);

    localparam int W2 = 2 * WIDTH;

    logic             load, shift_en, last, busy, done;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    valor_q, valor_d;
    logic [W2-1:0]    acc_sum;

    squarer_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (bus.start_i),
        .load_o     (load),
        .shift_en_o (shift_en),
        .last_o     (last),
        .busy_o     (busy),
        .done_o     (done)
    );

    // One partial product per step; the final sum is what DONE publishes
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Datapath next state: load on accept, shift-add while computing
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        valor_d  = valor_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.root_i};
            mplier_d = bus.root_i;
            acc_d    = '0;
        end else if (shift_en) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
        if (last) begin
            valor_d = acc_sum;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            valor_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            valor_q  <= valor_d;
        end
    end

    assign bus.busy_o  = busy;
    assign bus.ready_o = done;
    assign bus.valor_o = valor_q;

endmodule

// File: tb/tb_squarer_seq.sv
// Directed bench for squarer_seq: reset, latency, corner operands,
// ignored requests, back-to-back, mid-run reset and a full sweep.
module tb_squarer_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    squarer_seq_if #(.WIDTH(8)) bus ();

    squarer_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0;
        bus.root_i  = 8'hA5;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.start_i = ~bus.start_i;
            tick();
            n_checks += 3;
            if (bus.busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy cyc%0d got %b want 0", i, bus.busy_o);
            end
            if (bus.ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready cyc%0d got %b want 0", i, bus.ready_o);
            end
            if (bus.valor_o !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_valor cyc%0d got %h want 0000", i, bus.valor_o);
            end
        end
        bus.start_i = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle busy=%b ready=%b want 0/0",
                     bus.busy_o, bus.ready_o);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  roots [4];
        logic [15:0] exps  [4];
        roots = '{8'hFF, 8'h00, 8'h10, 8'h01};
        exps  = '{16'hFE01, 16'h0000, 16'h0100, 16'h0001};
        for (int v = 0; v < 4; v++) begin
            bus.start_i = 1'b1;
            bus.root_i  = roots[v];
            tick();
            bus.start_i = 1'b0;
            bus.root_i  = 8'h5A;
            for (int t = 1; t <= 8; t++) begin
                tick();
                n_checks++;
                if (bus.ready_o !== (t == 8)) begin
                    n_fail++;
                    $display("FAIL vec_latency root=%h edge%0d ready got %b want %b",
                             roots[v], t, bus.ready_o, (t == 8));
                end
                n_checks++;
                if (bus.busy_o !== (t != 8)) begin
                    n_fail++;
                    $display("FAIL vec_busy root=%h edge%0d got %b want %b",
                             roots[v], t, bus.busy_o, (t != 8));
                end
            end
            n_checks++;
            if (bus.valor_o !== exps[v]) begin
                n_fail++;
                $display("FAIL vec_valor root=%h got %h want %h",
                         roots[v], bus.valor_o, exps[v]);
            end
            tick();
            n_checks++;
            if (bus.ready_o !== 1'b0 || bus.valor_o !== exps[v]) begin
                n_fail++;
                $display("FAIL vec_hold root=%h ready=%b valor=%h want 0/%h",
                         roots[v], bus.ready_o, bus.valor_o, exps[v]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int pulses = 0;
        logic [15:0] seen = 16'hxxxx;
        bus.start_i = 1'b1;
        bus.root_i  = 8'h0C;
        tick();
        bus.start_i = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            bus.start_i = (t >= 2 && t <= 5);
            bus.root_i  = (t >= 2 && t <= 5) ? 8'h03 : 8'h77;
            tick();
            if (bus.ready_o === 1'b1) begin
                pulses++;
                seen = bus.valor_o;
            end
        end
        bus.start_i = 1'b0;
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL ignore_pulses got %0d want 1", pulses);
        end
        n_checks++;
        if (seen !== 16'h0090) begin
            n_fail++;
            $display("FAIL ignore_valor got %h want 0090", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v;
        bus.start_i = 1'b1;
        bus.root_i  = 8'h05;
        tick();
        bus.root_i  = 8'h07;
        for (int t = 1; t <= 17; t++) begin
            if (t == 17) begin
                tick();
                bus.start_i = 1'b0;
            end else begin
                tick();
            end
            n_checks++;
            if (bus.ready_o !== (t == 8 || t == 17)) begin
                n_fail++;
                $display("FAIL b2b_ready edge%0d got %b want %b",
                         t, bus.ready_o, (t == 8 || t == 17));
            end
            n_checks++;
            if (bus.busy_o !== !(t == 8 || t == 17)) begin
                n_fail++;
                $display("FAIL b2b_busy edge%0d got %b want %b",
                         t, bus.busy_o, !(t == 8 || t == 17));
            end
            if (t == 8 || t == 17) begin
                exp_v = (t == 8) ? 16'h0019 : 16'h0031;
                n_checks++;
                if (bus.valor_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_valor edge%0d got %h want %h",
                             t, bus.valor_o, exp_v);
                end
            end
        end
        tick();
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle busy=%b ready=%b want 0/0",
                     bus.busy_o, bus.ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.start_i = 1'b1;
        bus.root_i  = 8'h55;
        tick();
        bus.start_i = 1'b0;
        for (int t = 1; t <= 4; t++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 ||
            bus.valor_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_clear busy=%b ready=%b valor=%h want 0/0/0000",
                     bus.busy_o, bus.ready_o, bus.valor_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (bus.ready_o === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midrst_stray got %0d pulses want 0", pulses);
        end
        bus.start_i = 1'b1;
        bus.root_i  = 8'h80;
        tick();
        bus.start_i = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_checks++;
            if (bus.ready_o !== (t == 8)) begin
                n_fail++;
                $display("FAIL midrst_latency edge%0d got %b want %b",
                         t, bus.ready_o, (t == 8));
            end
        end
        n_checks++;
        if (bus.valor_o !== 16'h4000) begin
            n_fail++;
            $display("FAIL midrst_valor got %h want 4000", bus.valor_o);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [15:0] exp_v;
        for (int r = 0; r < 256; r++) begin
            exp_v = 16'(r * r);
            bus.start_i = 1'b1;
            bus.root_i  = 8'(r);
            tick();
            bus.start_i = 1'b0;
            bus.root_i  = 8'(~r);
            for (int t = 1; t <= 8; t++) tick();
            n_checks++;
            if (bus.ready_o !== 1'b1 || bus.valor_o !== exp_v) begin
                n_fail++;
                $display("FAIL sweep root=%0d ready=%b valor=%h want 1/%h",
                         r, bus.ready_o, bus.valor_o, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.root_i  = '0;
        test_reset();
        test_vectors();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
